// File: rtl/spi_rx_frame_ctrl_if.sv
// Purpose : bundles the SPI receiver-side inputs and FND-side outputs of the
//           frame controller into one port group.
// Latency : none (wires only).
// Backpr. : none; the byte stream is pulse-qualified by done, no ready path.
// Ports   : ss_n/rx_data/done come from the SPI slave receiver;
//           data/data_valid/frame_err/busy/err_cnt go to the FND controller.
//           master = receiver/driver side, slave = frame controller side.
interface spi_rx_frame_ctrl_if;
  logic        ss_n;        // slave select, active-low, synchronized to clk
  logic [7:0]  rx_data;     // received byte, valid while done==1
  logic        done;        // 1-cycle byte-complete pulse
  logic [13:0] data;        // committed display value
  logic        data_valid;  // 1-cycle pulse when data updates
  logic        frame_err;   // 1-cycle pulse on a discarded frame
  logic        busy;        // controller not idle
  logic [7:0]  err_cnt;     // saturating count of frame_err pulses

  modport master (
    output ss_n, rx_data, done,
    input  data, data_valid, frame_err, busy, err_cnt
  );

  modport slave (
    input  ss_n, rx_data, done,
    output data, data_valid, frame_err, busy, err_cnt
  );
endinterface

// File: rtl/spi_rx_frame_ctrl.sv
// Purpose : assembles a big-endian 2-byte SPI frame (optionally plus a
//           checksum byte) into a saturated 14-bit value for the FND counter.
// Latency : data/data_valid update 1 clk after the done of the final byte.
// Backpr. : none; bytes arriving outside an open frame slot are dropped.
// Ports   : clk, reset (synchronous, active-low), bus (spi_rx_frame_ctrl_if.slave).
// Config  : define SPI_FRAME_CKSUM_EN to require a third byte equal to
//           hi ^ lo ^ 8'hA5 before the value is committed.
module spi_rx_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000,  // 0 disables the timeout
  parameter int unsigned MAX_VALUE      = 9999
) (
  input  logic               clk,
  input  logic               reset,
  spi_rx_frame_ctrl_if.slave bus
);

  // Timer only has to reach TIMEOUT_CYCLES-1; it saturates so a disabled
  // timeout never wraps back to zero and re-arms the entry-glitch exception.
  localparam int unsigned   TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX  = '1;
  localparam logic [13:0]   MAX_V    = 14'(MAX_VALUE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HI     = 3'd1,
    S_LO     = 3'd2,
`ifdef SPI_FRAME_CKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_COMMIT = 3'd4,
    S_ERR    = 3'd5,
    S_DRAIN  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  // Only hi[5:0] is kept: a high byte with [7:6]!=0 never leaves HI for LO.
  logic [5:0]    hi_q, hi_d;
  logic [13:0]   data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
`ifdef SPI_FRAME_CKSUM_EN
  logic [7:0]    lo_q, lo_d;
`endif

  logic [TW-1:0] timer_inc;
  logic          timeout;
  logic [13:0]   frame_v;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hi_d         = hi_q;
    data_d       = data_q;
    err_cnt_d    = err_cnt_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef SPI_FRAME_CKSUM_EN
    lo_d         = lo_q;
    frame_v      = {hi_q, lo_q};
`else
    frame_v      = {hi_q, bus.rx_data};
`endif
    timer_inc    = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    timeout      = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

    // Within a frame slot a done always wins over ss_n rising or the timeout.
    case (state_q)
      S_IDLE: begin
        if (!bus.ss_n) begin
          state_d = S_HI;
          timer_d = '0;
        end
      end
      S_HI: begin
        timer_d = timer_inc;
        if (bus.done) begin
          hi_d    = bus.rx_data[5:0];
          timer_d = '0;
          // A good high byte with ss_n already released is still a short frame.
          state_d = (bus.rx_data[7:6] != 2'b00 || bus.ss_n) ? S_ERR : S_LO;
        end else if (bus.ss_n) begin
          // ss_n bounce in the very first HI cycle is treated as noise.
          state_d = (timer_q == '0) ? S_IDLE : S_ERR;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_LO: begin
        timer_d = timer_inc;
        if (bus.done) begin
          timer_d = '0;
`ifdef SPI_FRAME_CKSUM_EN
          lo_d    = bus.rx_data;
          state_d = bus.ss_n ? S_ERR : S_CHK;
`else
          state_d = S_COMMIT;
`endif
        end else if (bus.ss_n || timeout) begin
          state_d = S_ERR;
        end
      end
`ifdef SPI_FRAME_CKSUM_EN
      S_CHK: begin
        timer_d = timer_inc;
        if (bus.done) begin
          timer_d = '0;
          state_d = (bus.rx_data == ({2'b00, hi_q} ^ lo_q ^ 8'hA5)) ? S_COMMIT : S_ERR;
        end else if (bus.ss_n || timeout) begin
          state_d = S_ERR;
        end
      end
`endif
      S_COMMIT: state_d = S_DRAIN;
      S_ERR:    state_d = S_DRAIN;
      S_DRAIN: begin
        if (bus.ss_n) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    // COMMIT/ERR last exactly one cycle, so the registered pulses are loaded
    // on entry and line up with those states.
    if (state_d == S_COMMIT) begin
      data_d       = (frame_v > MAX_V) ? MAX_V : frame_v;
      data_valid_d = 1'b1;
    end
    if (state_d == S_ERR) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      hi_q         <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
`ifdef SPI_FRAME_CKSUM_EN
      lo_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hi_q         <= hi_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
`ifdef SPI_FRAME_CKSUM_EN
      lo_q         <= lo_d;
`endif
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// Testbench for spi_rx_frame_ctrl: vector table, hand-written corner-case
// sequences, and random frames scored by a frame-level reference model.
module tb_spi_rx_frame_ctrl;

  localparam int TO = 50;
`ifdef SPI_FRAME_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NB = CK ? 3 : 2;

  logic clk;
  logic reset;
  spi_rx_frame_ctrl_if bus ();

  spi_rx_frame_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_VALUE(9999)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int dv0, fe0;
  int exp_data = 0;
  int exp_errs = 0;
  logic        last_dv;
  logic [13:0] last_data;
  logic [7:0]  fb [$];
  int          fg [$];

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) dv_cnt = dv_cnt + 1;
    if (bus.frame_err === 1'b1)  fe_cnt = fe_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    dv0 = dv_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.done    = 1'b1;
    tick();
    bus.done    = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  // fb holds the bytes, fg the idle cycles before each byte plus one final
  // entry for the idle cycles before ss_n is released.
  task automatic run_frame();
    int n;
    n = fb.size();
    last_dv   = 1'b0;
    last_data = '0;
    bus.ss_n  = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      repeat (fg[i]) tick();
      send_byte(fb[i]);
      if (i == n - 1) begin
        last_dv   = bus.data_valid;
        last_data = bus.data;
      end
    end
    repeat (fg[n]) tick();
    bus.ss_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic post_checks(input string tag, input int exp_fe, input int exp_dv);
    check({tag, "_frame_err_pulses"}, fe_cnt - fe0, exp_fe);
    check({tag, "_data_valid_pulses"}, dv_cnt - dv0, exp_dv);
    check({tag, "_data"}, 32'(bus.data), exp_data);
    check({tag, "_err_cnt"}, 32'(bus.err_cnt), (exp_errs > 255) ? 255 : exp_errs);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  // Frame-level model: kind 0 = nothing happens, 1 = commit val, 2 = error.
  // A byte is late if it does not arrive within TO clock edges of the
  // previous event (frame start or previous byte).
  task automatic model_frame(output int kind, output int val);
    int n, hi, lo;
    n = fb.size(); kind = -1; val = 0; hi = 0; lo = 0;
    for (int i = 0; i < n && kind < 0; i++) begin
      if (fg[i] + 1 > TO) kind = 2;
      else if (i == 0) begin
        if (fb[0] > 63) kind = 2;
        else hi = fb[0];
      end else if (i == 1) begin
        lo = fb[1];
        if (NB == 2) begin kind = 1; val = sat(hi * 256 + lo); end
      end else begin
        if (int'(fb[2]) == (hi ^ lo ^ 165)) begin kind = 1; val = sat(hi * 256 + lo); end
        else kind = 2;
      end
    end
    // Frame ended early: only an immediate ss_n bounce is silent.
    if (kind < 0) kind = (n == 0 && fg[0] == 0) ? 0 : 2;
  endtask

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [13:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vt [11];

  initial begin
    int kind, val, k, n;
    logic [7:0] b;

    vt[0]  = '{8'h04, 8'hD2, 14'd1234, 1'b0};
    vt[1]  = '{8'h3F, 8'hFF, 14'd9999, 1'b0};
    vt[2]  = '{8'h40, 8'h00, 14'd9999, 1'b1};
    vt[3]  = '{8'h00, 8'h07, 14'd7,    1'b0};
    vt[4]  = '{8'h27, 8'h0E, 14'd9998, 1'b0};
    vt[5]  = '{8'h27, 8'h10, 14'd9999, 1'b0};
    vt[6]  = '{8'h00, 8'h00, 14'd0,    1'b0};
    vt[7]  = '{8'h27, 8'h0F, 14'd9999, 1'b0};
    vt[8]  = '{8'hC0, 8'h00, 14'd9999, 1'b1};
    vt[9]  = '{8'h80, 8'h12, 14'd9999, 1'b1};
    vt[10] = '{8'h01, 8'h00, 14'd256,  1'b0};

    bus.ss_n = 1'b1; bus.done = 1'b0; bus.rx_data = 8'h00;
    reset = 1'b0;
    repeat (2) tick();
    check("reset_data", 32'(bus.data), 0);
    check("reset_data_valid", 32'(bus.data_valid), 0);
    check("reset_frame_err", 32'(bus.frame_err), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_err_cnt", 32'(bus.err_cnt), 0);
    reset = 1'b1;
    tick();

    // vector table
    for (int r = 0; r < 11; r++) begin
      fb.delete(); fg.delete();
      fb.push_back(vt[r].hi); fb.push_back(vt[r].lo);
      fg.push_back(1); fg.push_back(2);
      if (CK) begin
        fb.push_back(vt[r].hi ^ vt[r].lo ^ 8'hA5);
        fg.push_back(2);
      end
      fg.push_back(1);
      snap();
      run_frame();
      exp_data = vt[r].exp_data;
      if (vt[r].exp_err) exp_errs++;
      check($sformatf("vec%0d_dv_after_last", r), 32'(last_dv), vt[r].exp_err ? 0 : 1);
      check($sformatf("vec%0d_data_after_last", r), 32'(last_data), 32'(vt[r].exp_data));
      post_checks($sformatf("vec%0d", r), vt[r].exp_err ? 1 : 0, vt[r].exp_err ? 0 : 1);
    end

    // abort after the high byte
    fb.delete(); fg.delete();
    fb.push_back(8'h01); fg.push_back(0); fg.push_back(3);
    snap(); run_frame(); exp_errs++;
    post_checks("abort", 1, 0);

    // ss_n bounce right after entry: silent
    fb.delete(); fg.delete(); fg.push_back(0);
    snap(); run_frame();
    post_checks("glitch", 0, 0);

    // timeout: frame_err exactly TO cycles after the first done, later done ignored
    snap();
    bus.ss_n = 1'b0; tick();
    send_byte(8'h00);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.frame_err === 1'b1) begin k = i; break; end
    end
    check("timeout_latency", k, TO);
    send_byte(8'h05);
    repeat (2) tick();
    bus.ss_n = 1'b1; repeat (3) tick();
    exp_errs++;
    post_checks("timeout", 1, 0);

    // extra bytes after a complete frame are ignored
    fb.delete(); fg.delete();
    fb.push_back(8'h00); fb.push_back(8'h2A);
    if (CK) fb.push_back(8'h8F);
    fb.push_back(8'h11);
    for (int i = 0; i <= fb.size(); i++) fg.push_back(1);
    snap(); run_frame(); exp_data = 42;
    post_checks("extra_bytes", 0, 1);

    // done and ss_n rising together on the last byte
    snap();
    bus.ss_n = 1'b0; tick();
    send_byte(8'h01);
    if (CK) send_byte(8'h55);
    tick();
    bus.rx_data = CK ? 8'hF1 : 8'h55; bus.done = 1'b1; bus.ss_n = 1'b1;
    tick();
    bus.done = 1'b0;
`ifdef SPI_FRAME_CKSUM_EN
    // 0x01 ^ 0x55 ^ 0xA5 = 0xF1
    exp_data = 341;
`else
    exp_data = 341;
`endif
    check("simul_last_dv", 32'(bus.data_valid), 1);
    repeat (3) tick();
    post_checks("simul_last", 0, 1);

    // done and ss_n rising together on the first byte
    snap();
    bus.ss_n = 1'b0; tick();
    bus.rx_data = 8'h01; bus.done = 1'b1; bus.ss_n = 1'b1;
    tick();
    bus.done = 1'b0;
    repeat (3) tick();
    exp_errs++;
    post_checks("simul_first", 1, 0);

`ifdef SPI_FRAME_CKSUM_EN
    fb.delete(); fg.delete();
    fb.push_back(8'h04); fb.push_back(8'hD2); fb.push_back(8'h00);
    for (int i = 0; i < 4; i++) fg.push_back(1);
    snap(); run_frame(); exp_errs++;
    post_checks("bad_cksum", 1, 0);
`endif

    // reset in the middle of a frame
    snap();
    bus.ss_n = 1'b0; tick();
    send_byte(8'h00);
    reset = 1'b0; bus.ss_n = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    exp_data = 0; exp_errs = 0;
    post_checks("mid_reset", 0, 0);

    // random frames against the reference model
    for (int f = 0; f < 60; f++) begin
      fb.delete(); fg.delete();
      n = $urandom_range(0, NB + 1);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (i == 0 && $urandom_range(0, 3) != 0) b[7:6] = 2'b00;
        if (i == 2 && CK && $urandom_range(0, 1) == 1) b = fb[0] ^ fb[1] ^ 8'hA5;
        fb.push_back(b);
      end
      for (int i = 0; i <= n; i++)
        fg.push_back(($urandom_range(0, 9) == 0) ? 55 : $urandom_range(0, 12));
      model_frame(kind, val);
      snap(); run_frame();
      if (kind == 1) exp_data = val;
      if (kind == 2) exp_errs++;
      post_checks($sformatf("rand%0d", f), (kind == 2) ? 1 : 0, (kind == 1) ? 1 : 0);
    end

    // err_cnt saturation
    snap();
    for (int i = 0; i < 260; i++) begin
      fb.delete(); fg.delete(); fg.push_back(1);
      run_frame();
    end
    exp_errs += 260;
    post_checks("err_sat", 260, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_rx_frame_ctrl.md
Name: spi_rx_frame_ctrl

Overview:
- Frame controller between the SPI slave receiver and the 4-digit FND controller.
- Takes byte-complete pulses and received bytes, framed by slave select, and assembles a 2-byte big-endian frame into a 14-bit display value.
- Handles aborts, timeouts, range saturation and error counting.
- Drives the FND controller's counter input with a registered, glitch-free value.

Parameters:
- TIMEOUT_CYCLES, 100_000, max clk cycles allowed between frame start/previous byte and the next byte; 0 disables timeout.
- MAX_VALUE, 9999, saturation ceiling for the assembled value.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (reset==0 resets on rising clk)
- ss_n  input  1  slave select, active-low, already synchronized to clk
- rx_data  input  8  received byte; valid only in the cycle done==1
- done  input  1  1-cycle byte-complete pulse from the SPI slave receiver
- data  output  14  committed display value to FND controller
- data_valid  output  1  1-cycle pulse when data updates
- frame_err  output  1  1-cycle pulse on any discarded frame
- busy  output  1  high in any state other than IDLE
- err_cnt  output  8  saturating count of frame_err pulses

Behaviour:
- Reset (reset==0 at clk edge) gives: state=IDLE, data=0, data_valid=0, frame_err=0, err_cnt=0, internal hi/lo/timer=0.
- Reset mid-frame discards everything with no err pulse.
- States and transitions:
  - IDLE: ss_n==0 -> HI (timer cleared). done in IDLE is ignored.
  - HI: on done, latch hi=rx_data.
    - If rx_data[7:6]!=0 -> ERR; else -> LO.
  - LO: on done, latch lo=rx_data -> COMMIT (or CHK, see Optional Feature).
  - COMMIT, one cycle:
    - v = {hi[5:0], lo}.
    - data <= (v > MAX_VALUE) ? MAX_VALUE : v.
    - data_valid=1.
    - -> DRAIN.
  - ERR, one cycle: frame_err=1, err_cnt += 1 (holds at 255) -> DRAIN.
  - DRAIN: further done pulses are ignored. ss_n==1 -> IDLE.
- Abort: ss_n==1 in HI/LO/CHK with no done that cycle -> ERR.
  - Exception: in HI with timer==0 (ss_n glitch right after entry) -> IDLE, no error.
- Simultaneous done and ss_n==1 in the same cycle: done is processed first.
  - If it completes the frame: COMMIT, then DRAIN sees ss_n==1 -> IDLE.
  - Otherwise -> ERR.
- Timeout:
  - Timer clears on entry to HI/LO/CHK and on each accepted done; it increments every cycle in those states.
  - timer == TIMEOUT_CYCLES-1 with no done -> ERR.
  - TIMEOUT_CYCLES==0 disables the timer.
- Latency: data and data_valid update 1 clk after the done of the final byte.
- data holds its value between commits, including across aborted frames.
- Outputs are registered: frame_err, data_valid and data come from flops; busy is decoded from the state register.
- State encoding is implementer's choice; an illegal state recovers to IDLE on the next clk.

Optional Feature:
- Macro: SPI_FRAME_CKSUM_EN.
- Defined: a third byte is required. LO -> CHK on the low byte. In CHK, on done:
  - rx_data == (hi ^ lo ^ 8'hA5) -> COMMIT.
  - Otherwise -> ERR.
  - CHK obeys the same abort and timeout rules.
- Undefined: CHK state and its logic are not compiled; LO goes directly to COMMIT.

Test Plan:
- Normal frame: reset low 2 cycles; ss_n=0; bytes 0x04, 0xD2; ss_n=1 -> data=1234 one clk after second done, data_valid single pulse, frame_err never asserted, busy back to 0 after ss_n rises.
- Saturation: bytes 0x3F, 0xFF (v=16383) -> data=9999, data_valid pulse. Bytes 0x40, 0x00 -> frame_err pulse, err_cnt=1, data stays 9999.
- Abort: ss_n low, byte 0x01, ss_n high before second byte -> frame_err pulse, data unchanged, state IDLE. Next full frame 0x00, 0x07 -> data=7.
- Timeout: TIMEOUT_CYCLES=50; send 0x00, then hold ss_n low for 60 cycles -> frame_err exactly 50 cycles after the first done. A later done while still low is ignored (DRAIN); data unchanged.
- Extra bytes and reset: frame 0x00, 0x2A, 0x11 then ss_n=1 -> data=42, a single data_valid pulse. Assert reset after the first byte of the next frame -> data=0, err_cnt=0, busy=0, no frame_err.
- With SPI_FRAME_CKSUM_EN: bytes 0x04, 0xD2, 0x73 -> data=1234. Bytes 0x04, 0xD2, 0x00 -> frame_err pulse, data unchanged, err_cnt increments.
